// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and default width for the add-shift multiplier sequencer
package mult_pkg;
  localparam int MULT_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, HOLD} mult_state_t;
endpackage

// File: rtl/mult_bit_counter.sv
// mult_bit_counter: iteration index for the multiplier sequencer, flags the final bit
module mult_bit_counter
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic inc,
  output logic last
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  assign last = cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: counter-based control FSM for the signed add-shift multiplier datapath
// Define MULT_SEQ_ABORT_EN to let an Execute release abort a running sequence.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic Clk,
  input  logic Reset,
  input  logic ClearA_LoadB,
  input  logic Execute,
  input  logic M,
  output logic Clr_Ld,
  output logic Clear_XA,
  output logic Add,
  output logic Sub,
  output logic Shift,
  output logic Busy,
  output logic Done
);
`ifdef MULT_SEQ_ABORT_EN
  localparam logic ABORT = 1'b1;
`else
  localparam logic ABORT = 1'b0;
`endif
  mult_state_t state, next;
  logic clr, inc, last;
  mult_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (clr),
    .inc   (inc),
    .last  (last)
  );
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next     = state;
    clr      = 1'b0;
    inc      = 1'b0;
    Clr_Ld   = 1'b0;
    Clear_XA = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift    = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state)
      IDLE: begin
        Clr_Ld = ClearA_LoadB;
        next   = Execute ? CLEAR : IDLE;
      end
      CLEAR: begin
        Clear_XA = 1'b1;
        Busy     = 1'b1;
        clr      = 1'b1;
        next     = ADD;
      end
      ADD: begin
        Busy = 1'b1;
        Add  = M & ~last;
        Sub  = M & last;
        next = SHIFT;
      end
      SHIFT: begin
        Shift = 1'b1;
        Busy  = 1'b1;
        inc   = ~last;
        next  = last ? HOLD : ADD;
      end
      HOLD: begin
        Done = 1'b1;
        next = Execute ? HOLD : IDLE;
      end
      default: next = IDLE;
    endcase
    // abort only ever applies while busy; HOLD/IDLE keep their own Execute handling
    if (ABORT && !Execute && Busy) begin
      next = IDLE;
      clr  = 1'b1;
    end
  end
endmodule
